tetris_input_ctrl: RTL

//  Upstream command stage for the tetris core. Converts debounced button levels into

---
 rtl/tetris_input_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/tetris_input_ctrl.sv
// Button-to-command front end for the tetris core: edge detection, DAS/auto-repeat,
// level-scaled gravity and a valid/ready command register fed by per-source pending bits.
module tetris_input_ctrl #(
  parameter int unsigned DAS_CYCLES     = 8_000_000,
  parameter int unsigned ARR_CYCLES     = 2_500_000,
  parameter int unsigned GRAVITY_CYCLES = 25_000_000,
  parameter int unsigned CNT_W          = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       enable,
  input  logic [3:0] level,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready
);
  typedef enum logic [1:0] {REP_IDLE, REP_DAS, REP_REPEAT} rep_state_t;
  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_ROTATE = 3'd2,
    CMD_LEFT   = 3'd3,
    CMD_RIGHT  = 3'd4,
    CMD_DOWN   = 3'd5
  } cmd_t;

  localparam int unsigned P_ROT   = 0;
  localparam int unsigned P_LEFT  = 1;
  localparam int unsigned P_DOWN  = 2;
  localparam int unsigned P_GRAV  = 3;
  localparam int unsigned P_RIGHT = 4;

  localparam logic [CNT_W-1:0] DAS_LAST    = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST    = CNT_W'(ARR_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRAV_PERIOD = CNT_W'(GRAVITY_CYCLES);

  logic [3:0]       btn_q;
  logic [3:0]       press;
  logic [2:0]       rep_btn;
  logic [2:0]       rep_press;
  logic [2:0]       rep_expire;
  rep_state_t       rep_state [3];
  logic [CNT_W-1:0] rep_timer [3];
  logic [CNT_W-1:0] grav_cnt;
  logic [CNT_W-1:0] grav_period;
  logic [CNT_W-1:0] grav_last;
  logic [2:0]       lvl;
  logic             grav_expire;
  logic             load;
  logic             down_accept;
  logic [4:0]       pend;
  logic [4:0]       events;
  logic [4:0]       sel_clear;
  logic [4:0]       clear_mask;
  cmd_t             sel_cmd;

  // Repeat channels: 0 = left (btn[2]), 1 = down (btn[1]), 2 = right (btn[0]).
  assign press     = btn & ~btn_q;
  assign rep_btn   = {btn[0], btn[1], btn[2]};
  assign rep_press = {press[0], press[1], press[2]};

  always_comb begin
    rep_expire = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      case (rep_state[i])
        REP_DAS:    rep_expire[i] = rep_btn[i] && (rep_timer[i] == DAS_LAST);
        REP_REPEAT: rep_expire[i] = rep_btn[i] && (rep_timer[i] == ARR_LAST);
        default:    rep_expire[i] = 1'b0;
      endcase
    end
  end

  // A period that shifts down to zero behaves as a one-cycle period.
  assign lvl         = (level > 4'd7) ? 3'd7 : level[2:0];
  assign grav_period = GRAV_PERIOD >> lvl;
  assign grav_last   = (grav_period == '0) ? '0 : grav_period - CNT_W'(1);
  assign grav_expire = grav_cnt >= grav_last;

  assign events = {rep_press[2] | rep_expire[2], grav_expire,
                   rep_press[1] | rep_expire[1], rep_press[0] | rep_expire[0], press[3]};

  assign load        = !cmd_valid || cmd_ready;
  assign down_accept = cmd_valid && cmd_ready && (cmd == CMD_DOWN);

  always_comb begin
    sel_clear = '0;
    sel_cmd   = CMD_NONE;
    if (pend[P_ROT]) begin
      sel_clear[P_ROT] = 1'b1;
      sel_cmd          = CMD_ROTATE;
    end else if (pend[P_LEFT]) begin
      sel_clear[P_LEFT] = 1'b1;
      sel_cmd           = CMD_LEFT;
    end else if (pend[P_DOWN] || pend[P_GRAV]) begin
      sel_clear[P_DOWN] = 1'b1;
      sel_clear[P_GRAV] = 1'b1;
      sel_cmd           = CMD_DOWN;
    end else if (pend[P_RIGHT]) begin
      sel_clear[P_RIGHT] = 1'b1;
      sel_cmd            = CMD_RIGHT;
    end
  end

  assign clear_mask = load ? sel_clear : '0;

  always_ff @(posedge clk) begin
    btn_q <= btn;
    if (reset || !enable) begin
      pend      <= '0;
      cmd       <= CMD_NONE;
      cmd_valid <= 1'b0;
      grav_cnt  <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        rep_state[i] <= REP_IDLE;
        rep_timer[i] <= '0;
      end
    end else begin
      // The load clears its bit first; a same-edge event for that source re-arms it.
      pend <= (pend & ~clear_mask) | events;
      if (load) begin
        cmd       <= sel_cmd;
        cmd_valid <= (sel_cmd != CMD_NONE);
      end
      grav_cnt <= (grav_expire || down_accept) ? '0 : grav_cnt + CNT_W'(1);
      for (int unsigned i = 0; i < 3; i++) begin
        if (!rep_btn[i]) begin
          rep_state[i] <= REP_IDLE;
          rep_timer[i] <= '0;
        end else begin
          case (rep_state[i])
            REP_IDLE: begin
              if (rep_press[i]) begin
                rep_state[i] <= REP_DAS;
                rep_timer[i] <= '0;
              end
            end
            REP_DAS: begin
              if (rep_expire[i]) begin
                rep_state[i] <= REP_REPEAT;
                rep_timer[i] <= '0;
              end else begin
                rep_timer[i] <= rep_timer[i] + CNT_W'(1);
              end
            end
            default: begin
              rep_timer[i] <= rep_expire[i] ? '0 : rep_timer[i] + CNT_W'(1);
            end
          endcase
        end
      end
    end
  end
endmodule
